// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: one op in flight, IDLE/EXEC/RESP.
// Define ALU_ARB_RR_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned DW  = 32,
    parameter int unsigned OPW = 6
) (
    input  logic           clk_i,
    input  logic           resetn_i,
    input  logic [1:0]     req_valid_i,
    output logic [1:0]     req_ready_o,
    input  logic [OPW-1:0] req_op0_i,
    input  logic [OPW-1:0] req_op1_i,
    input  logic [DW-1:0]  req_a0_i,
    input  logic [DW-1:0]  req_b0_i,
    input  logic [DW-1:0]  req_a1_i,
    input  logic [DW-1:0]  req_b1_i,
    output logic [OPW-1:0] alu_op_o,
    output logic [DW-1:0]  alu_rv1_o,
    output logic [DW-1:0]  alu_rv2_o,
    input  logic [DW-1:0]  alu_rvout_i,
    output logic [1:0]     rsp_valid_o,
    input  logic [1:0]     rsp_ready_i,
    output logic [DW-1:0]  rsp_data_o,
    output logic           rsp_err_o,
    output logic           busy_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  a_q, b_q, res_q;
    logic           gnt_q, err_q;
    logic           gnt_sel, prio, accept, rsp_done, op_legal;

`ifdef ALU_ARB_RR_EN
    logic ptr_q;

    assign prio = ptr_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ptr_q <= 1'b0;
        end else if (rsp_done) begin
            ptr_q <= ~ptr_q;
        end
    end
`else
    assign prio = 1'b0;
`endif

    always_comb begin
        gnt_sel = 1'b0;
        if (req_valid_i == 2'b10) begin
            gnt_sel = 1'b1;
        end else if (req_valid_i == 2'b11) begin
            gnt_sel = prio;
        end
    end

    assign accept   = (state_q == StIdle) && (req_valid_i != 2'b00);
    assign rsp_done = (state_q == StResp) && rsp_ready_i[gnt_q];

    always_comb begin
        case (op_q[4:0])
            5'b01000, 5'b11000, 5'b01001, 5'b01010, 5'b01011,
            5'b01100, 5'b01101, 5'b11101, 5'b01110, 5'b01111: op_legal = 1'b1;
            default:                                          op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gnt_q   <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_q <= gnt_sel;
                op_q  <= gnt_sel ? req_op1_i : req_op0_i;
                a_q   <= gnt_sel ? req_a1_i : req_a0_i;
                b_q   <= gnt_sel ? req_b1_i : req_b0_i;
            end
            if (state_q == StExec) begin
                // Illegal ops report zero rather than whatever the ALU produced.
                res_q <= op_legal ? alu_rvout_i : '0;
                err_q <= ~op_legal;
            end
        end
    end

    always_comb begin
        req_ready_o = 2'b00;
        if (accept) begin
            req_ready_o = gnt_sel ? 2'b10 : 2'b01;
        end
        rsp_valid_o = 2'b00;
        if (state_q == StResp) begin
            rsp_valid_o = gnt_q ? 2'b10 : 2'b01;
        end
    end

    assign alu_op_o   = op_q;
    assign alu_rv1_o  = a_q;
    assign alu_rv2_o  = b_q;
    assign rsp_data_o = res_q;
    assign rsp_err_o  = err_q;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
// Honours ALU_ARB_RR_EN the same way as the design.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [5:0]  req_op0, req_op1, alu_op;
    logic [31:0] req_a0, req_b0, req_a1, req_b1, alu_rv1, alu_rv2, alu_rvout, rsp_data;
    logic        rsp_err, busy;

`ifdef ALU_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    localparam logic [4:0] LegalOps [10] = '{5'b01000, 5'b11000, 5'b01001, 5'b01010, 5'b01011,
                                             5'b01100, 5'b01101, 5'b11101, 5'b01110, 5'b01111};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(32), .OPW(6)) dut (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op0_i   (req_op0),
        .req_op1_i   (req_op1),
        .req_a0_i    (req_a0),
        .req_b0_i    (req_b0),
        .req_a1_i    (req_a1),
        .req_b1_i    (req_b1),
        .alu_op_o    (alu_op),
        .alu_rv1_o   (alu_rv1),
        .alu_rv2_o   (alu_rv2),
        .alu_rvout_i (alu_rvout),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy)
    );

    function automatic logic is_legal(input logic [5:0] op);
        is_legal = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (op[4:0] == LegalOps[i]) is_legal = 1'b1;
        end
    endfunction

    // Shared ALU stand-in; illegal codes return junk so the arbiter's zeroing is observable.
    function automatic logic [31:0] alu_calc(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op[4:0])
            5'b01000: alu_calc = a + b;
            5'b11000: alu_calc = a - b;
            5'b01001: alu_calc = a << b[4:0];
            5'b01010: alu_calc = {31'd0, $signed(a) < $signed(b)};
            5'b01011: alu_calc = {31'd0, a < b};
            5'b01100: alu_calc = a ^ b;
            5'b01101: alu_calc = a >> b[4:0];
            5'b11101: alu_calc = $unsigned($signed(a) >>> b[4:0]);
            5'b01110: alu_calc = a | b;
            5'b01111: alu_calc = a & b;
            default:  alu_calc = a ^ b ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_rvout = alu_calc(alu_op, alu_rv1, alu_rv2);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one pending transaction, who should win, and what it should return.
    logic        m_busy = 1'b0;
    logic        m_ptr  = 1'b0;
    int          m_id, m_acc, cyc;
    logic [31:0] m_data;
    logic        m_err;
    int          gnt_cnt [2];
    logic [1:0]  exp_rdy;
    int          w;

    always @(negedge clk) begin
        if (!resetn) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end else begin
            cyc++;
            if (!m_busy) begin
                check_eq("busy_idle", busy, 0);
                check_eq("rsp_valid_idle", rsp_valid, 0);
                if (req_valid == 2'b01)      w = 0;
                else if (req_valid == 2'b10) w = 1;
                else                         w = (RrEn && m_ptr) ? 1 : 0;
                exp_rdy = 2'b00;
                if (req_valid != 2'b00) exp_rdy[w] = 1'b1;
                check_eq("req_ready_idle", req_ready, exp_rdy);
                if (req_valid != 2'b00) begin
                    m_busy = 1'b1;
                    m_id   = w;
                    m_acc  = cyc;
                    if (w == 1) begin
                        m_err  = !is_legal(req_op1);
                        m_data = m_err ? 32'd0 : alu_calc(req_op1, req_a1, req_b1);
                    end else begin
                        m_err  = !is_legal(req_op0);
                        m_data = m_err ? 32'd0 : alu_calc(req_op0, req_a0, req_b0);
                    end
                    gnt_cnt[w]++;
                end
            end else begin
                check_eq("req_ready_busy", req_ready, 0);
                check_eq("busy_busy", busy, 1);
                if (cyc - m_acc == 1) begin
                    check_eq("rsp_valid_exec", rsp_valid, 0);
                end else begin
                    check_eq("rsp_valid_resp", rsp_valid, (m_id == 1) ? 2'b10 : 2'b01);
                    check_eq("rsp_data", rsp_data, m_data);
                    check_eq("rsp_err", rsp_err, m_err);
                    if (rsp_ready[m_id]) begin
                        m_busy = 1'b0;
                        m_ptr  = ~m_ptr;
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_rsp_err"}, rsp_err, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_alu_op"}, alu_op, 0);
        check_eq({tag, "_alu_rv1"}, alu_rv1, 0);
        check_eq({tag, "_alu_rv2"}, alu_rv2, 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rand_op();
        int k = $urandom_range(0, 11);
        if (k < 10) return {1'($urandom_range(0, 1)), LegalOps[k]};
        return 6'($urandom);
    endfunction

    initial begin
        resetn    = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        #3;
        check_all_zero("reset");
        cycles(1);
        resetn = 1'b1;

        // ADD 5+7 from requester 0, granted on the first edge after reset release
        req_valid = 2'b01; req_op0 = 6'b001000; req_a0 = 32'd5; req_b0 = 32'd7;
        rsp_ready = 2'b01;
        cycles(1);
        req_valid = 2'b00; req_a0 = 32'd99;
        @(negedge clk);
        @(negedge clk);
        check_eq("add_valid", rsp_valid, 2'b01);
        check_eq("add_data", rsp_data, 32'd12);
        check_eq("add_err", rsp_err, 0);
        cycles(3);

        // Sustained contention: SUB 10-3 vs XOR F0^0F
        gnt_cnt[0] = 0; gnt_cnt[1] = 0;
        req_op0 = 6'b011000; req_a0 = 32'd10; req_b0 = 32'd3;
        req_op1 = 6'b001100; req_a1 = 32'hF0; req_b1 = 32'h0F;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 30 && (gnt_cnt[0] + gnt_cnt[1]) < 4; i++) cycles(1);
        req_valid = 2'b00;
        cycles(4);
        check_eq("contend_gnt0", gnt_cnt[0], RrEn ? 2 : 4);
        check_eq("contend_gnt1", gnt_cnt[1], RrEn ? 2 : 0);

        // Response back-pressure for more than 10 cycles
        req_valid = 2'b01; req_op0 = 6'b001111; req_a0 = 32'hFF00_FF00; req_b0 = 32'h0FF0_0FF0;
        rsp_ready = 2'b10;
        cycles(1);
        req_valid = 2'b00; req_a0 = 32'h1234_5678;
        cycles(13);
        check_eq("stall_busy", busy, 1);
        rsp_ready = 2'b01;
        cycles(3);

        // Illegal op from requester 1
        req_valid = 2'b10; req_op1 = 6'b000000; req_a1 = 32'h55; req_b1 = 32'hAA;
        rsp_ready = 2'b00;
        cycles(1);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check_eq("illegal_valid", rsp_valid, 2'b10);
        check_eq("illegal_err", rsp_err, 1);
        check_eq("illegal_data", rsp_data, 0);
        rsp_ready = 2'b10;
        cycles(3);

        // Asynchronous reset while the op is in EXEC
        req_valid = 2'b01; req_op0 = 6'b001000; req_a0 = 32'd1; req_b0 = 32'd2;
        rsp_ready = 2'b11;
        cycles(1);
        req_valid = 2'b00;
        #1 resetn = 1'b0;
        #1 check_all_zero("midreset");
        cycles(1);
        resetn = 1'b1;
        cycles(4);
        check_eq("midreset_no_rsp", rsp_valid, 0);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 800; i++) begin
            req_valid = 2'($urandom);
            req_op0   = rand_op();
            req_op1   = rand_op();
            req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
            rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
            cycles(1);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        cycles(5);
        check_eq("drained", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
